// File: rtl/microtile_sel_ctrl_pkg.sv
// Shared types and defaults for the micro-tile select controller.
// Holds the FSM state encoding, the default sizing constants and the one-hot helper.
package microtile_pkg;

  localparam int NUM_TILES       = 4;
  localparam int SEL_W           = $clog2(NUM_TILES);
  localparam int RST_HOLD_CYCLES = 8;
  localparam int QUIESCE_CYCLES  = 2;

  // Widest tile count the one-hot helper supports; callers truncate to their width.
  localparam int MAX_TILES = 32;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_QUIESCE = 2'd2
  } state_e;

  function automatic logic [MAX_TILES-1:0] onehot(input logic [31:0] idx);
    return MAX_TILES'(1) << idx;
  endfunction

endpackage

// File: rtl/microtile_sel_ctrl_if.sv
// Select request and per-tile control bundle between the controller and its container.
// The controller sits on the slave side; the container or bench drives as master.
interface microtile_sel_ctrl_if #(
  parameter int NUM_TILES = microtile_pkg::NUM_TILES,
  parameter int SEL_W     = $clog2(NUM_TILES)
);

  logic [SEL_W-1:0]     sel_req;
  logic [SEL_W-1:0]     sel_active;
  logic [NUM_TILES-1:0] tile_clk_en;
  logic [NUM_TILES-1:0] tile_rst_n;
  logic                 out_valid;
  logic                 busy;
  logic [7:0]           switch_cnt;

  modport master (
    output sel_req,
    input  sel_active, tile_clk_en, tile_rst_n, out_valid, busy, switch_cnt
  );

  modport slave (
    input  sel_req,
    output sel_active, tile_clk_en, tile_rst_n, out_valid, busy, switch_cnt
  );

endinterface

// File: rtl/microtile_sel_ctrl_sync.sv
// Synchroniser for the asynchronous select pins plus a stability counter.
// stable_o is high in each enabled cycle where the synced select has held STABLE_CYCLES cycles.
module microtile_sel_sync #(
  parameter int SEL_W         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_req_i,
  output logic [SEL_W-1:0] sel_s_o,
  output logic             stable_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_q;
  logic [SEL_W-1:0]                  prev_q;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  assign sel_s_o = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sel_req_i};
      prev_q <= sel_s_o;
      cnt_q  <= cnt_d;
    end
  end

  // Saturate at STABLE_CYCLES so a held value keeps stable_o asserted.
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      if (sel_s_o != prev_q)
        cnt_d = CNT_W'(1);
      else if (cnt_q == CNT_W'(STABLE_CYCLES))
        cnt_d = cnt_q;
      else
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = en_i && (cnt_d == CNT_W'(STABLE_CYCLES));

endmodule

// File: rtl/microtile_sel_ctrl.sv
// Tile handover sequencer: debounced select, clock-gated quiesce, held reset, then run.
// All outputs are registered from the next-state values.
module microtile_sel_ctrl #(
  parameter int NUM_TILES       = microtile_pkg::NUM_TILES,
  parameter int SEL_W           = $clog2(NUM_TILES),
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 4,
  parameter int RST_HOLD_CYCLES = microtile_pkg::RST_HOLD_CYCLES,
  parameter int QUIESCE_CYCLES  = microtile_pkg::QUIESCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  microtile_sel_ctrl_if.slave  bus
);

  import microtile_pkg::*;

  localparam int TMR_MAX = (RST_HOLD_CYCLES > QUIESCE_CYCLES) ? RST_HOLD_CYCLES : QUIESCE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [SEL_W-1:0]     pending_q, pending_d;
  logic [SEL_W-1:0]     sel_active_q, sel_active_d;
  logic [7:0]           switch_cnt_q, switch_cnt_d;
  logic [NUM_TILES-1:0] clk_en_q, clk_en_d;
  logic [NUM_TILES-1:0] tile_rst_n_q, tile_rst_n_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [SEL_W-1:0]     sel_s;
  logic                 stable;
  logic                 fire;

  microtile_sel_sync #(
    .SEL_W         (SEL_W),
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == ST_RUN),
    .sel_req_i (bus.sel_req),
    .sel_s_o   (sel_s),
    .stable_o  (stable)
  );

  // Out-of-range codes count as "same tile" and never start a handover.
  assign fire = stable && (sel_s != sel_active_q) && (32'(sel_s) < 32'(NUM_TILES));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TMR_W'(1);
    pending_d    = pending_q;
    sel_active_d = sel_active_q;
    switch_cnt_d = switch_cnt_q;

    unique case (state_q)
      ST_RESET: begin
        // Right after async reset the outputs are still zero: that cycle is the entry, not hold.
        if (clk_en_q == '0) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(RST_HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        timer_d = '0;
        if (fire) begin
          state_d      = ST_QUIESCE;
          pending_d    = sel_s;
          switch_cnt_d = switch_cnt_q + 8'd1;
        end
      end
      ST_QUIESCE: begin
        if (timer_q == TMR_W'(QUIESCE_CYCLES - 1)) begin
          state_d      = ST_RESET;
          timer_d      = '0;
          sel_active_d = pending_q;
        end
      end
      default: begin
        state_d = ST_RESET;
        timer_d = '0;
      end
    endcase

    clk_en_d     = '0;
    tile_rst_n_d = '0;
    out_valid_d  = 1'b0;
    busy_d       = 1'b1;
    unique case (state_d)
      ST_RESET: clk_en_d = NUM_TILES'(onehot(32'(sel_active_d)));
      ST_RUN: begin
        clk_en_d     = NUM_TILES'(onehot(32'(sel_active_d)));
        tile_rst_n_d = NUM_TILES'(onehot(32'(sel_active_d)));
        out_valid_d  = 1'b1;
        busy_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      timer_q      <= '0;
      pending_q    <= '0;
      sel_active_q <= '0;
      switch_cnt_q <= '0;
      clk_en_q     <= '0;
      tile_rst_n_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      sel_active_q <= sel_active_d;
      switch_cnt_q <= switch_cnt_d;
      clk_en_q     <= clk_en_d;
      tile_rst_n_q <= tile_rst_n_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sel_active  = sel_active_q;
  assign bus.tile_clk_en = clk_en_q;
  assign bus.tile_rst_n  = tile_rst_n_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.switch_cnt  = switch_cnt_q;

endmodule

// File: tb/tb_microtile_sel_ctrl.sv
// Directed bench for microtile_sel_ctrl: reset, debounce, handover timing, async reset, wrap.
// Expected values come from hand-derived cycle tables relative to each stimulus edge.
module tb_microtile_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  microtile_sel_ctrl_if bus ();

  microtile_sel_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] sa;
    logic [3:0] en;
    logic [3:0] rst;
    logic       ov;
    logic       busy;
    logic [7:0] cnt;
  } obs_t;

  function automatic logic [3:0] oh(input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0001 << s;
    return r;
  endfunction

  function automatic obs_t observe();
    return {bus.sel_active, bus.tile_clk_en, bus.tile_rst_n, bus.out_valid, bus.busy, bus.switch_cnt};
  endfunction

  function automatic obs_t mk(input logic [1:0] sa, input logic [3:0] en, input logic [3:0] rst,
                              input logic ov, input logic busy, input logic [7:0] cnt);
    return {sa, en, rst, ov, busy, cnt};
  endfunction

  // Expected outputs k edges after a request, with QUIESCE entered on edge q_at.
  function automatic obs_t exp_handover(input int k, input int q_at, input logic [1:0] old_s,
                                        input logic [1:0] new_s, input logic [7:0] cnt0);
    if (k < q_at)           return mk(old_s, oh(old_s), oh(old_s), 1'b1, 1'b0, cnt0);
    else if (k < q_at + 2)  return mk(old_s, 4'b0000, 4'b0000, 1'b0, 1'b1, cnt0 + 8'd1);
    else if (k < q_at + 10) return mk(new_s, oh(new_s), 4'b0000, 1'b0, 1'b1, cnt0 + 8'd1);
    else                    return mk(new_s, oh(new_s), oh(new_s), 1'b1, 1'b0, cnt0 + 8'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants on the clock enables and resets, sampled on the falling edge.
  logic [3:0] prev_en = 4'b0000;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if ($countones(bus.tile_clk_en) > 1 ||
          (bus.tile_clk_en != 4'b0000 && bus.tile_clk_en != oh(bus.sel_active)) ||
          (prev_en != 4'b0000 && bus.tile_clk_en != 4'b0000 && prev_en != bus.tile_clk_en) ||
          (bus.tile_rst_n != 4'b0000 && bus.tile_rst_n != oh(bus.sel_active))) begin
        n_bad++;
        $display("FAIL invariant t=%0t en=%b prev_en=%b rst=%b sa=%0d", $time,
                 bus.tile_clk_en, prev_en, bus.tile_rst_n, bus.sel_active);
      end
    end
    prev_en = bus.tile_clk_en;
  end

  task automatic test_reset();
    obs_t got, want;
    rst_n = 1'b0;
    bus.sel_req = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    got = observe();
    want = mk(2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd0);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_values got=%h want=%h", got, want);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      got = observe();
      want = (k <= 8) ? mk(2'd0, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'd0)
                      : mk(2'd0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset_release k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_glitch();
    obs_t got, want;
    bus.sel_req = 2'd3;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) bus.sel_req = 2'd0;
      got = observe();
      want = exp_handover(k, 1000, 2'd0, 2'd0, 8'd0);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL glitch k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_switch();
    obs_t got, want;
    bus.sel_req = 2'd2;
    for (int k = 1; k <= 17; k++) begin
      tick();
      got = observe();
      want = exp_handover(k, 6, 2'd0, 2'd2, 8'd0);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL switch_0_to_2 k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, want;
    bus.sel_req = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      got = observe();
      want = exp_handover(k, 6, 2'd2, 2'd1, 8'd1);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL pre_async k=%0d got=%h want=%h", k, got, want);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = observe();
    want = mk(2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd0);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL async_reset_in_quiesce got=%h want=%h", got, want);
    end
    bus.sel_req = 2'd0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      got = observe();
      want = (k <= 8) ? mk(2'd0, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'd0)
                      : mk(2'd0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd0);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL restart_tile0 k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_change_in_reset();
    obs_t got, want;
    bus.sel_req = 2'd1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8) bus.sel_req = 2'd3;
      got = observe();
      want = exp_handover(k, 6, 2'd0, 2'd1, 8'd0);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL first_handover k=%0d got=%h want=%h", k, got, want);
      end
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      got = observe();
      want = exp_handover(k, 4, 2'd1, 2'd3, 8'd1);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL second_handover k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] target;
    int t;
    rst_n = 1'b0;
    bus.sel_req = 2'd0;
    tick();
    rst_n = 1'b1;
    t = 0;
    while (bus.out_valid !== 1'b1 && t < 30) begin tick(); t++; end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_start_timeout out_valid=%b want=1", bus.out_valid);
    end
    for (int i = 0; i < 256; i++) begin
      target = (i % 2 == 0) ? 2'd1 : 2'd0;
      bus.sel_req = target;
      t = 0;
      while (bus.busy !== 1'b1 && t < 20) begin tick(); t++; end
      t = 0;
      while (bus.out_valid !== 1'b1 && t < 30) begin tick(); t++; end
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.sel_active !== target) begin
        n_bad++;
        $display("FAIL wrap_switch i=%0d sel_active=%0d out_valid=%b want sel=%0d valid=1",
                 i, bus.sel_active, bus.out_valid, target);
      end
      if (i == 254) begin
        n_cmp++;
        if (bus.switch_cnt !== 8'd255) begin
          n_bad++;
          $display("FAIL switch_cnt_255 got=%0d want=255", bus.switch_cnt);
        end
      end
    end
    n_cmp++;
    if (bus.switch_cnt !== 8'd0 || bus.sel_active !== 2'd0) begin
      n_bad++;
      $display("FAIL switch_cnt_wrap got cnt=%0d sa=%0d want cnt=0 sa=0", bus.switch_cnt, bus.sel_active);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_switch();
    test_async_reset();
    test_change_in_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
